// File: rtl/alarm_interval_timer_pkg.sv
// alarm_interval_timer_pkg
// Shared definitions for the anti-theft alarm datapath: the interval timer
// state encoding, the interval select codes used by the alarm FSM and the
// time-parameter block, the default system clock rate, and a helper that
// sizes prescaler counters.
`timescale 1ns/1ps
package alarm_interval_timer_pkg;

    // Interval timer states
    typedef enum logic [1:0] {
        TMR_IDLE     = 2'b00,
        TMR_COUNTING = 2'b01,
        TMR_EXPIRED  = 2'b10
    } timer_state_e;

    // Interval select codes driven by the alarm FSM into the parameter block
    typedef enum logic [1:0] {
        ARM_DELAY       = 2'b00,
        DRIVER_DELAY    = 2'b01,
        PASSENGER_DELAY = 2'b10,
        ALARM_ON        = 2'b11
    } interval_sel_e;

    // System clock cycles per second on the target board
    localparam int DEFAULT_CLK_FREQ = 100_000_000;

    // Counter width able to hold 0..freq-1, never narrower than one bit
    function automatic int prescale_width(input int freq);
        return (freq > 1) ? $clog2(freq) : 1;
    endfunction

endpackage

// File: rtl/alarm_interval_timer_if.sv
// alarm_interval_timer_if
// Bundle between the alarm FSM (master) and the interval timer (slave).
//   start_timer   FSM -> timer  load value and (re)start the countdown
//   value         FSM -> timer  seconds to count (from the parameter block)
//   expired       timer -> FSM  high while the timer is in EXPIRED
//   expired_pulse timer -> FSM  one-cycle pulse on entry to EXPIRED
//   running       timer -> FSM  high while counting
//   seconds_left  timer -> FSM  remaining seconds, display/debug
//   tick_1hz      timer -> FSM  one-cycle prescaler tick
`timescale 1ns/1ps
interface alarm_interval_timer_if #(
    parameter int WIDTH = 4
);
    logic             start_timer;
    logic [WIDTH-1:0] value;
    logic             expired;
    logic             expired_pulse;
    logic             running;
    logic [WIDTH-1:0] seconds_left;
    logic             tick_1hz;

    modport master (
        output start_timer,
        output value,
        input  expired,
        input  expired_pulse,
        input  running,
        input  seconds_left,
        input  tick_1hz
    );

    modport slave (
        input  start_timer,
        input  value,
        output expired,
        output expired_pulse,
        output running,
        output seconds_left,
        output tick_1hz
    );
endinterface

// File: rtl/alarm_interval_timer_one_hz_prescaler.sv
// one_hz_prescaler
// Divides the system clock down to a one-cycle tick every CLK_FREQ cycles.
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous active-high reset
//   enable  count while high; counter held at 0 otherwise
//   clear   synchronous restart of the count from 0 (dominates enable)
//   tick    registered tick, high for the cycle after the counter wraps
//   wrap    combinational: tick will register on the coming edge, for
//           consumers that must act on the same edge as the tick
`timescale 1ns/1ps
module one_hz_prescaler
    import alarm_interval_timer_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick,
    output logic wrap
);

    localparam int            CW   = prescale_width(CLK_FREQ);
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] count_q;

    assign wrap = enable && !clear && (count_q == LAST);

    // Counter runs 0..CLK_FREQ-1 while enabled; a clear restarts the
    // interval so the first tick lands exactly CLK_FREQ edges later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick    <= 1'b0;
        end else if (clear || !enable) begin
            count_q <= '0;
            tick    <= 1'b0;
        end else if (count_q == LAST) begin
            count_q <= '0;
            tick    <= 1'b1;
        end else begin
            count_q <= count_q + 1'b1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/alarm_interval_timer.sv
// alarm_interval_timer
// Countdown timer for the alarm datapath. A start_timer pulse samples the
// selected interval (seconds), which is counted down at 1 Hz; on reaching
// zero the timer enters EXPIRED and flags the alarm FSM until restarted.
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-high reset
//   tmr_bus   slave side of alarm_interval_timer_if (start_timer, value in;
//             expired, expired_pulse, running, seconds_left, tick_1hz out)
`timescale 1ns/1ps
module alarm_interval_timer
    import alarm_interval_timer_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int WIDTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    alarm_interval_timer_if.slave tmr_bus
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] seconds_q, seconds_d;
    logic             pulse_q, pulse_d;
    logic             expired_q, running_q;
    logic             prescale_tick;
    logic             prescale_wrap;

    // The prescaler only runs while counting; a start always restarts it so
    // a retrigger gets a full first second.
    one_hz_prescaler #(
        .CLK_FREQ (CLK_FREQ)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q == TMR_COUNTING),
        .clear  (tmr_bus.start_timer),
        .tick   (prescale_tick),
        .wrap   (prescale_wrap)
    );

    // State and all outputs are registered; expired/running are stored
    // rather than decoded so they cannot glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= TMR_IDLE;
            seconds_q <= '0;
            pulse_q   <= 1'b0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seconds_q <= seconds_d;
            pulse_q   <= pulse_d;
            expired_q <= (state_d == TMR_EXPIRED);
            running_q <= (state_d == TMR_COUNTING);
        end
    end

    // Start has priority over everything, including a coinciding final
    // tick, so a reload never produces a stale expiry. The decrement acts on
    // the edge where the prescaler tick registers, which makes the start to
    // expiry latency exactly value*CLK_FREQ cycles.
    always_comb begin
        state_d   = state_q;
        seconds_d = seconds_q;
        pulse_d   = 1'b0;
        if (tmr_bus.start_timer) begin
            seconds_d = tmr_bus.value;
            if (tmr_bus.value != '0) begin
                state_d = TMR_COUNTING;
            end else begin
                state_d = TMR_EXPIRED;
                pulse_d = 1'b1;
            end
        end else begin
            case (state_q)
                TMR_IDLE: begin
                    state_d = TMR_IDLE;
                end
                TMR_COUNTING: begin
                    if (prescale_wrap) begin
                        if (seconds_q <= WIDTH'(1)) begin
                            seconds_d = '0;
                            state_d   = TMR_EXPIRED;
                            pulse_d   = 1'b1;
                        end else begin
                            seconds_d = seconds_q - 1'b1;
                        end
                    end
                end
                TMR_EXPIRED: begin
                    seconds_d = '0;
                end
                default: begin
                    state_d   = TMR_IDLE;
                    seconds_d = '0;
                end
            endcase
        end
    end

    assign tmr_bus.expired       = expired_q;
    assign tmr_bus.expired_pulse = pulse_q;
    assign tmr_bus.running       = running_q;
    assign tmr_bus.seconds_left  = seconds_q;
    assign tmr_bus.tick_1hz      = prescale_tick;

endmodule

// File: tb/tb_alarm_interval_timer.sv
// tb_alarm_interval_timer
// Directed bench for alarm_interval_timer with CLK_FREQ=4. Inputs are
// driven just after a rising edge, outputs are sampled 1 ns after the edge.
`timescale 1ns/1ps
module tb_alarm_interval_timer;

    localparam int CLK_FREQ = 4;
    localparam int WIDTH    = 4;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   pulse_count;
    int   tick_count;
    int   base;

    alarm_interval_timer_if #(.WIDTH(WIDTH)) tb_bus ();

    alarm_interval_timer #(
        .CLK_FREQ (CLK_FREQ),
        .WIDTH    (WIDTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .tmr_bus (tb_bus.slave)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Running tallies of pulses and ticks, sampled mid-cycle
    initial begin
        pulse_count = 0;
        tick_count  = 0;
    end
    always @(negedge clock) begin
        if (tb_bus.expired_pulse) pulse_count++;
        if (tb_bus.tick_1hz)      tick_count++;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present start/value for exactly one rising edge; returns 1 ns after it
    task automatic applyStimulus(input logic start, input logic [WIDTH-1:0] val);
        tb_bus.start_timer = start;
        tb_bus.value       = val;
        waitCycles(1);
        tb_bus.start_timer = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        waitCycles(1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_expired"}, int'(tb_bus.expired), 0);
        checkOutput({tag, "_pulse"},   int'(tb_bus.expired_pulse), 0);
        checkOutput({tag, "_running"}, int'(tb_bus.running), 0);
        checkOutput({tag, "_seconds"}, int'(tb_bus.seconds_left), 0);
        checkOutput({tag, "_tick"},    int'(tb_bus.tick_1hz), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        tb_bus.start_timer = 1'b0;
        tb_bus.value       = '0;
        #2;
        checkAllZero("reset");
        @(negedge clock);
        reset = 1'b0;
        waitCycles(1);

        // value=6 countdown, expiry 24 cycles after the start edge
        $display("[TB] basic countdown value=6");
        applyStimulus(1'b1, 4'd6);
        checkOutput("t1_running", int'(tb_bus.running), 1);
        checkOutput("t1_sec_load", int'(tb_bus.seconds_left), 6);
        waitCycles(3);
        checkOutput("t1_sec_k3", int'(tb_bus.seconds_left), 6);
        checkOutput("t1_tick_k3", int'(tb_bus.tick_1hz), 0);
        waitCycles(1);
        checkOutput("t1_sec_k4", int'(tb_bus.seconds_left), 5);
        checkOutput("t1_tick_k4", int'(tb_bus.tick_1hz), 1);
        waitCycles(1);
        checkOutput("t1_tick_k5", int'(tb_bus.tick_1hz), 0);
        waitCycles(3);
        checkOutput("t1_sec_k8", int'(tb_bus.seconds_left), 4);
        waitCycles(15);
        checkOutput("t1_sec_k23", int'(tb_bus.seconds_left), 1);
        checkOutput("t1_exp_k23", int'(tb_bus.expired), 0);
        waitCycles(1);
        checkOutput("t1_exp_k24", int'(tb_bus.expired), 1);
        checkOutput("t1_pulse_k24", int'(tb_bus.expired_pulse), 1);
        checkOutput("t1_sec_k24", int'(tb_bus.seconds_left), 0);
        checkOutput("t1_run_k24", int'(tb_bus.running), 0);
        waitCycles(1);
        checkOutput("t1_pulse_k25", int'(tb_bus.expired_pulse), 0);
        checkOutput("t1_exp_k25", int'(tb_bus.expired), 1);

        // value=0 goes straight to EXPIRED without ticking
        $display("[TB] zero value start");
        pulseReset();
        base = tick_count;
        applyStimulus(1'b1, 4'd0);
        checkOutput("t2_expired", int'(tb_bus.expired), 1);
        checkOutput("t2_pulse", int'(tb_bus.expired_pulse), 1);
        checkOutput("t2_running", int'(tb_bus.running), 0);
        waitCycles(1);
        checkOutput("t2_pulse_next", int'(tb_bus.expired_pulse), 0);
        waitCycles(10);
        checkOutput("t2_ticks", tick_count - base, 0);
        checkOutput("t2_expired_hold", int'(tb_bus.expired), 1);

        // Retrigger mid-count restarts the full interval
        $display("[TB] retrigger 8 -> 3");
        pulseReset();
        base = pulse_count;
        applyStimulus(1'b1, 4'd8);
        waitCycles(9);
        applyStimulus(1'b1, 4'd3);
        checkOutput("t3_sec_reload", int'(tb_bus.seconds_left), 3);
        checkOutput("t3_running", int'(tb_bus.running), 1);
        waitCycles(11);
        checkOutput("t3_exp_early", int'(tb_bus.expired), 0);
        checkOutput("t3_no_pulse_yet", pulse_count - base, 0);
        waitCycles(1);
        checkOutput("t3_exp_12", int'(tb_bus.expired), 1);
        checkOutput("t3_pulse_12", int'(tb_bus.expired_pulse), 1);
        waitCycles(15);
        checkOutput("t3_single_pulse", pulse_count - base, 1);

        // Asynchronous reset mid-count
        $display("[TB] async reset mid-count");
        pulseReset();
        applyStimulus(1'b1, 4'd15);
        waitCycles(8);
        checkOutput("t4_running_pre", int'(tb_bus.running), 1);
        #1;
        reset = 1'b1;
        #1;
        checkAllZero("t4_async");
        base = pulse_count;
        @(negedge clock);
        reset = 1'b0;
        waitCycles(70);
        checkOutput("t4_no_pulse", pulse_count - base, 0);
        checkOutput("t4_idle_exp", int'(tb_bus.expired), 0);
        applyStimulus(1'b1, 4'd2);
        waitCycles(7);
        checkOutput("t4_exp_k7", int'(tb_bus.expired), 0);
        waitCycles(1);
        checkOutput("t4_exp_k8", int'(tb_bus.expired), 1);

        // Start on the final tick edge: reload wins
        $display("[TB] start on final tick");
        pulseReset();
        applyStimulus(1'b1, 4'd1);
        waitCycles(3);
        base = pulse_count;
        applyStimulus(1'b1, 4'd5);
        checkOutput("t5_expired", int'(tb_bus.expired), 0);
        checkOutput("t5_pulse", int'(tb_bus.expired_pulse), 0);
        checkOutput("t5_sec", int'(tb_bus.seconds_left), 5);
        checkOutput("t5_running", int'(tb_bus.running), 1);
        waitCycles(2);
        checkOutput("t5_no_pulse", pulse_count - base, 0);
        waitCycles(17);
        checkOutput("t5_exp_k19", int'(tb_bus.expired), 0);
        waitCycles(1);
        checkOutput("t5_exp_k20", int'(tb_bus.expired), 1);

        // value changes mid-count are ignored; expired holds until restart
        $display("[TB] value change mid-count and long hold");
        pulseReset();
        applyStimulus(1'b1, 4'd10);
        waitCycles(4);
        tb_bus.value = 4'd2;
        waitCycles(35);
        checkOutput("t6_exp_k39", int'(tb_bus.expired), 0);
        checkOutput("t6_sec_k39", int'(tb_bus.seconds_left), 1);
        waitCycles(1);
        checkOutput("t6_exp_k40", int'(tb_bus.expired), 1);
        waitCycles(55);
        checkOutput("t6_exp_hold", int'(tb_bus.expired), 1);
        checkOutput("t6_sec_hold", int'(tb_bus.seconds_left), 0);
        applyStimulus(1'b1, 4'd3);
        checkOutput("t6_exp_clear", int'(tb_bus.expired), 0);
        checkOutput("t6_run_restart", int'(tb_bus.running), 1);
        checkOutput("t6_sec_restart", int'(tb_bus.seconds_left), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_interval_timer.md
Name: alarm_interval_timer

Overview:
- Countdown timer that sits directly downstream of the time-parameter register block in the anti-theft alarm datapath.
- Samples the selected 4-bit `value` (seconds) when the alarm FSM pulses `start_timer`.
- Counts it down at 1 Hz from an internal prescaler, then flags `expired` back to the FSM.
- The FSM drives `interval` into the parameter block; this block only consumes the resulting `value`.

Parameters:
- CLK_FREQ, 100_000_000, clock cycles per 1-second tick; benches override with a small value (e.g. 4).
- WIDTH, 4, width of `value` and of the second counter.

Ports:
- clock  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- start_timer  input  1  load `value` and (re)start the countdown; level sampled at each rising edge
- value  input  WIDTH  seconds to count, from the parameter block (combinational, stable when `start_timer`=1)
- expired  output  1  high while in EXPIRED state
- expired_pulse  output  1  single-cycle pulse on entry to EXPIRED
- running  output  1  high while in COUNTING state
- seconds_left  output  WIDTH  current remaining seconds, for display/debug
- tick_1hz  output  1  prescaler tick, one cycle wide

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all counters 0.
  - expired=0, expired_pulse=0, running=0, seconds_left=0, tick_1hz=0.
  - Reset mid-count aborts with no expired pulse.
- States: IDLE, COUNTING, EXPIRED. Encoding is 2-bit, all outputs registered.
- `start_timer`=1 at edge k, in any state:
  - seconds_left<=value and the prescaler clears to 0.
  - If value≠0, state<=COUNTING.
  - If value==0, state<=EXPIRED directly, with expired_pulse=1 after edge k.
- Prescaler:
  - Counts 0..CLK_FREQ-1 while in COUNTING and asserts tick_1hz for the cycle it wraps.
  - The first tick registers at edge k+CLK_FREQ.
  - Outside COUNTING the prescaler holds at 0 and tick_1hz=0.
  - Width is $clog2(CLK_FREQ), minimum 1.
- COUNTING, on each tick edge:
  - seconds_left decrements by 1.
  - On the tick where seconds_left==1: seconds_left<=0, state<=EXPIRED, expired_pulse<=1 for that one cycle.
  - Latency from start edge to expired is exactly value*CLK_FREQ cycles.
- EXPIRED:
  - expired stays high until the next start_timer or reset. seconds_left stays 0.
  - Only a start_timer leaves EXPIRED. Returning to IDLE needs no separate clear.
- IDLE: holds until start_timer.
- Simultaneous events:
  - start_timer on the same edge as a tick: start wins. Reload occurs, no decrement, prescaler restarts.
  - start_timer on the same edge as the final tick: reload wins, and no expired or expired_pulse is produced.
- `value` is sampled only on the start edge. Changes to `value` mid-count have no effect.
- Decrement never underflows. seconds_left is never decremented at 0.
- Retrigger in COUNTING restarts the full interval. Retrigger in EXPIRED clears expired on the next edge.

Decomposition:
- Shared alarm package holds:
  - timer state encoding: TMR_IDLE=2'b00, TMR_COUNTING=2'b01, TMR_EXPIRED=2'b10.
  - interval select constants shared with the FSM and the parameter block: ARM_DELAY=2'b00, DRIVER_DELAY=2'b01, PASSENGER_DELAY=2'b10, ALARM_ON=2'b11.
  - DEFAULT_CLK_FREQ.
- One sub-module: `one_hz_prescaler`.
  - Inputs: clock, reset, enable, clear. Output: tick.
  - Parameterised by CLK_FREQ.
  - Reused later by the siren/LED blink logic.

Test Plan (CLK_FREQ=4):
- Reset, then start_timer=1 for 1 cycle with value=6: running=1, seconds_left=6; decrements every 4 cycles; expired_pulse and expired rise exactly 24 cycles after the start edge, and seconds_left=0.
- start_timer with value=0: no COUNTING; expired=1 and a single-cycle expired_pulse after the next edge; tick_1hz never asserts.
- value=8 started, re-started at cycle 10 with value=3: seconds_left=3 after the restart edge; expired 12 cycles after the restart, never at the original 32.
- value=15 started, reset asserted asynchronously mid-cycle at cycle 9: all outputs 0 immediately without waiting for a clock edge; no expired_pulse afterwards; a subsequent start with value=2 works normally (8 cycles).
- start_timer asserted exactly on the final tick edge of a value=1 count: no expired_pulse; a new countdown of the new value begins.
- value changed from 10 to 2 at cycle 5 after a start with 10: still expires at cycle 40. While EXPIRED, expired holds for 50+ idle cycles until a new start clears it.
